// File: rtl/fft_spectrum_buffer.sv
// Captures the low half of each FFT magnitude frame as clipped bar heights in a
// ping-pong RAM; a frame becomes readable only after it has been fully received.
module fft_spectrum_buffer #(
    parameter int FFT_LEN    = 1024,
    parameter int BIN_NUM    = 512,
    parameter int DATA_W     = 32,
    parameter int HEIGHT_W   = 10,
    parameter int SHIFT      = 8,
    parameter int MAX_HEIGHT = 540
) (
    input  logic                       sys_clk,
    input  logic                       sys_rstn,
    input  logic [DATA_W-1:0]          fft_data,
    input  logic                       fft_sop,
    input  logic                       fft_eop,
    input  logic                       fft_valid,
    input  logic                       rd_en,
    input  logic [$clog2(BIN_NUM)-1:0] rd_addr,
    output logic [HEIGHT_W-1:0]        rd_height,
    output logic                       rd_valid,
    output logic                       frame_done,
    output logic                       frame_err,
    output logic                       bank_sel,
    output logic                       frame_ready
);

    localparam int AW = $clog2(BIN_NUM);
    localparam int CW = $clog2(FFT_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DROP    = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  bank_sel_q;
    logic                  frame_ready_q;
    logic                  frame_done_q;
    logic                  frame_err_q;
    logic                  err_d;
    logic [HEIGHT_W-1:0]   rd_height_q;
    logic                  rd_valid_q;
    logic                  we_s;
    logic [AW-1:0]         waddr_s;
    logic [HEIGHT_W-1:0]   height_s;
    logic                  last_s;
    logic                  commit_s;

    logic [HEIGHT_W-1:0]   mem_q [2*BIN_NUM];

    function automatic logic [HEIGHT_W-1:0] scale_height(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] sh;
        sh = d >> SHIFT;
        if (sh > DATA_W'(MAX_HEIGHT)) begin
            scale_height = HEIGHT_W'(MAX_HEIGHT);
        end else begin
            scale_height = sh[HEIGHT_W-1:0];
        end
    endfunction

    assign height_s = scale_height(fft_data);
    assign last_s   = (cnt_q == CW'(FFT_LEN - 1));
    assign commit_s = (state_q == COMMIT);

    // Frame tracking: restart on any sop beat, keep bins below BIN_NUM, validate length on eop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_s    = 1'b0;
        waddr_s = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE, CAPTURE, DROP: begin
                if (fft_valid && fft_sop) begin
                    we_s    = 1'b1;
                    waddr_s = '0;
                    if (fft_eop) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        err_d   = (state_q != IDLE);
                        cnt_d   = CW'(1);
                        state_d = (BIN_NUM > 1) ? CAPTURE : DROP;
                    end
                end else if (fft_valid && (state_q != IDLE)) begin
                    if (state_q == CAPTURE) begin
                        we_s    = 1'b1;
                        waddr_s = cnt_q[AW-1:0];
                    end else begin
                        we_s    = 1'b0;
                    end
                    if (fft_eop) begin
                        cnt_d   = '0;
                        state_d = last_s ? COMMIT : IDLE;
                        err_d   = !last_s;
                    end else if (last_s) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if ((state_q == CAPTURE) && (cnt_q == CW'(BIN_NUM - 1))) begin
                            state_d = DROP;
                        end else begin
                            state_d = state_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            COMMIT: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Control state, bank ownership and status pulses.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bank_sel_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bank_sel_q    <= bank_sel_q ^ commit_s;
            frame_ready_q <= frame_ready_q | commit_s;
            frame_done_q  <= commit_s;
            frame_err_q   <= err_d;
        end
    end

    // Height RAM write into the bank not being displayed; contents are not reset.
    always_ff @(posedge sys_clk) begin
        if (we_s) begin
            mem_q[{~bank_sel_q, waddr_s}] <= height_s;
        end
    end

    // Read port: uses the bank displayed in the request cycle, so a same-cycle swap reads the old bank.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rd_height_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                if (frame_ready_q && ({1'b0, rd_addr} < (AW+1)'(BIN_NUM))) begin
                    rd_height_q <= mem_q[{bank_sel_q, rd_addr}];
                end else begin
                    rd_height_q <= '0;
                end
            end else begin
                rd_height_q <= rd_height_q;
            end
        end
    end

    assign rd_height   = rd_height_q;
    assign rd_valid    = rd_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign bank_sel    = bank_sel_q;
    assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_fft_spectrum_buffer.sv
// Directed bench for fft_spectrum_buffer: frame capture, clipping, error frames,
// restarts, valid gaps and mid-frame reset.
module tb_fft_spectrum_buffer;

    logic        sys_clk = 1'b0;
    logic        sys_rstn;
    logic [31:0] fft_data;
    logic        fft_sop, fft_eop, fft_valid;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [9:0]  rd_height;
    logic        rd_valid, frame_done, frame_err, bank_sel, frame_ready;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    fft_spectrum_buffer dut (
        .sys_clk    (sys_clk),
        .sys_rstn   (sys_rstn),
        .fft_data   (fft_data),
        .fft_sop    (fft_sop),
        .fft_eop    (fft_eop),
        .fft_valid  (fft_valid),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_height  (rd_height),
        .rd_valid   (rd_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .bank_sel   (bank_sel),
        .frame_ready(frame_ready)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulses last one cycle, so each is seen at exactly one falling edge.
    always @(negedge sys_clk) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
        if (frame_err  === 1'b1) err_cnt  <= err_cnt + 1;
    end

    function automatic logic [31:0] gen(input int kind, input int i);
        case (kind)
            0:       gen = 32'(i) << 8;
            1:       gen = (i == 5) ? (32'd539 << 8) : 32'hFFFF_FFFF;
            2:       gen = 32'(i + 7) << 8;
            default: gen = 32'(1023 - i) << 8;
        endcase
    endfunction

    function automatic logic [9:0] exp_h(input int kind, input int i);
        case (kind)
            0:       exp_h = 10'(i);
            1:       exp_h = (i == 5) ? 10'd539 : 10'd540;
            2:       exp_h = 10'(i + 7);
            default: exp_h = (1023 - i > 540) ? 10'd540 : 10'(1023 - i);
        endcase
    endfunction

    task automatic beat(input logic [31:0] d, input logic s, input logic e, input logic v);
        fft_data = d; fft_sop = s; fft_eop = e; fft_valid = v;
        @(posedge sys_clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) beat(32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Returns #1 after the edge that samples the last beat.
    task automatic send(input int kind, input int n, input int eop_idx, input bit gaps);
        for (int i = 0; i < n; i++) begin
            beat(gen(kind, i), (i == 0), (i == eop_idx), 1'b1);
            if (gaps && i != n - 1) beat($urandom, 1'b1, 1'b1, 1'b0);
        end
        fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0;
    endtask

    task automatic read_check(input string name, input int kind, input bit ready, input int nbins);
        for (int a = 0; a < nbins; a++) begin
            rd_en = 1'b1; rd_addr = 9'(a);
            @(posedge sys_clk); #1;
            n_chk++;
            if (rd_valid !== 1'b1) $display("FAIL %s rd_valid addr %0d got %b want 1", name, a, rd_valid);
            else n_pass++;
            n_chk++;
            if (rd_height !== (ready ? exp_h(kind, a) : 10'd0))
                $display("FAIL %s height addr %0d got %0d want %0d", name, a, rd_height,
                         ready ? exp_h(kind, a) : 10'd0);
            else n_pass++;
        end
        rd_en = 1'b0;
        @(posedge sys_clk); #1;
        n_chk++;
        if (rd_valid !== 1'b0) $display("FAIL %s rd_valid_low got %b want 0", name, rd_valid);
        else n_pass++;
    endtask

    task automatic check_frame(input string name, input int d0, input int e0,
                               input int dd, input int de, input logic bsel);
        idle(3);
        n_chk++;
        if (done_cnt - d0 !== dd) $display("FAIL %s done_count got %0d want %0d", name, done_cnt - d0, dd);
        else n_pass++;
        n_chk++;
        if (err_cnt - e0 !== de) $display("FAIL %s err_count got %0d want %0d", name, err_cnt - e0, de);
        else n_pass++;
        n_chk++;
        if (bank_sel !== bsel) $display("FAIL %s bank_sel got %b want %b", name, bank_sel, bsel);
        else n_pass++;
    endtask

    task automatic test_reset();
        sys_rstn = 1'b0; rd_en = 1'b0; rd_addr = 9'd0;
        fft_data = 32'd0; fft_sop = 1'b0; fft_eop = 1'b0; fft_valid = 1'b0;
        repeat (3) @(posedge sys_clk); #1;
        n_chk++;
        if ({rd_height, rd_valid, frame_done, frame_err, bank_sel, frame_ready} !== 15'd0)
            $display("FAIL reset_outputs got %h want 0",
                     {rd_height, rd_valid, frame_done, frame_err, bank_sel, frame_ready});
        else n_pass++;
        sys_rstn = 1'b1;
        idle(2);
        read_check("pre_commit", 0, 1'b0, 3);
    endtask

    task automatic test_frame();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(0, 1024, 1023, 1'b0);
        n_chk++;
        if (frame_done !== 1'b0 || bank_sel !== 1'b0)
            $display("FAIL latency_early done=%b bank=%b want 0 0", frame_done, bank_sel);
        else n_pass++;
        @(posedge sys_clk); #1;
        n_chk++;
        if (frame_done !== 1'b1 || bank_sel !== 1'b1 || frame_ready !== 1'b1)
            $display("FAIL latency_commit done=%b bank=%b ready=%b want 1 1 1", frame_done, bank_sel, frame_ready);
        else n_pass++;
        check_frame("frame", d0, e0, 1, 0, 1'b1);
        read_check("frame", 0, 1'b1, 512);
    endtask

    task automatic test_clip();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(1, 1024, 1023, 1'b0);
        check_frame("clip", d0, e0, 1, 0, 1'b0);
        read_check("clip", 1, 1'b1, 16);
    endtask

    task automatic test_short_eop();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(3, 701, 700, 1'b0);
        check_frame("short_eop", d0, e0, 0, 1, 1'b0);
        read_check("short_eop", 1, 1'b1, 16);
    endtask

    task automatic test_restart();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(3, 300, -1, 1'b0);
        send(2, 1024, 1023, 1'b0);
        check_frame("restart", d0, e0, 1, 1, 1'b1);
        read_check("restart", 2, 1'b1, 512);
    endtask

    task automatic test_sop_eop_beat();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        beat(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        check_frame("sop_eop", d0, e0, 0, 1, 1'b1);
        read_check("sop_eop", 2, 1'b1, 8);
    endtask

    task automatic test_no_eop();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(3, 1024, -1, 1'b0);
        check_frame("no_eop", d0, e0, 0, 1, 1'b1);
        read_check("no_eop", 2, 1'b1, 8);
    endtask

    task automatic test_mid_reset();
        int d0, e0;
        send(3, 200, -1, 1'b0);
        sys_rstn = 1'b0;
        #2;
        n_chk++;
        if ({frame_ready, bank_sel, rd_valid, frame_done, frame_err} !== 5'd0 || rd_height !== 10'd0)
            $display("FAIL mid_reset_outputs ready=%b bank=%b height=%0d want 0",
                     frame_ready, bank_sel, rd_height);
        else n_pass++;
        @(posedge sys_clk); #1;
        sys_rstn = 1'b1;
        idle(1);
        read_check("after_reset", 0, 1'b0, 4);
        d0 = done_cnt; e0 = err_cnt;
        send(2, 1024, 1023, 1'b0);
        check_frame("mid_reset", d0, e0, 1, 0, 1'b1);
        n_chk++;
        if (frame_ready !== 1'b1) $display("FAIL mid_reset_ready got %b want 1", frame_ready);
        else n_pass++;
        read_check("mid_reset", 2, 1'b1, 512);
    endtask

    task automatic test_gaps();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(0, 1024, 1023, 1'b1);
        check_frame("gaps", d0, e0, 1, 0, 1'b0);
        read_check("gaps", 0, 1'b1, 512);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_clip();
        test_short_eop();
        test_restart();
        test_sop_eop_beat();
        test_no_eop();
        test_mid_reset();
        test_gaps();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
